// File: rtl/egr_pfs_pkg.sv
// Shared defaults and types for the egress packet fetch scheduler.
package egr_pfs_pkg;

  localparam int unsigned PFS_NUM_Q   = 8;
  localparam int unsigned PFS_QID_W   = $clog2(PFS_NUM_Q);
  localparam int unsigned PFS_CNT_W   = 10;
  localparam int unsigned PFS_CREDITS = 4;

  typedef logic [PFS_QID_W-1:0] qid_t;
  typedef logic [PFS_CNT_W-1:0] pcnt_t;

endpackage : egr_pfs_pkg

// File: rtl/egr_rr_arb.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... ending at ptr.
module egr_rr_arb #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 gnt_valid_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int i = N; i >= 1; i--) begin
      idx = IW'(ptr_i + IW'(i));
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule : egr_rr_arb

// File: rtl/egr_pfs_sched.sv
// Egress packet fetch scheduler: per-queue pending counts, credit-limited
// round-robin selection, one registered fetch request toward the PRC.
module egr_pfs_sched
  import egr_pfs_pkg::*;
#(
  parameter int unsigned NUM_Q   = PFS_NUM_Q,
  parameter int unsigned QID_W   = $clog2(NUM_Q),
  parameter int unsigned CNT_W   = PFS_CNT_W,
  parameter int unsigned CREDITS = PFS_CREDITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  logic [QID_W-1:0] enq_qid,
  input  logic [NUM_Q-1:0] pause,
  input  logic             credit_return,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [QID_W-1:0] req_qid,
  output logic             ovf_err,
  output logic             crd_err
);

  localparam int unsigned     CRD_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDITS);

  logic [CNT_W-1:0] cnt_q [NUM_Q];
  logic [CNT_W-1:0] cnt_d [NUM_Q];
  logic [CRD_W-1:0] crd_q, crd_d;
  logic [QID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             req_valid_q, req_valid_d;
  logic [QID_W-1:0] req_qid_q, req_qid_d;
  logic             ovf_err_q, ovf_err_d;
  logic             crd_err_q, crd_err_d;

  logic [NUM_Q-1:0] elig;
  logic [NUM_Q-1:0] enq_hit;
  logic [NUM_Q-1:0] gnt_hit;
  logic             gnt_valid;
  logic [QID_W-1:0] gnt_idx;
  logic             slot_free;
  logic             grant;

  // Eligibility: pending work, not paused, and a credit to spend.
  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      elig[q] = (cnt_q[q] != '0) && !pause[q] && (crd_q != '0);
    end
  end

  egr_rr_arb #(.N(NUM_Q)) u_arb (
    .req_i       (elig),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign slot_free = !req_valid_q || req_ready;
  assign grant     = slot_free && gnt_valid;

  // Per-queue decode of enqueue and grant events.
  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      enq_hit[q] = enq_valid && (enq_qid == QID_W'(q));
      gnt_hit[q] = grant && (gnt_idx == QID_W'(q));
    end
  end

  // Next-state for counters, credits, pointer, request slot and sticky errors.
  always_comb begin
    cnt_d       = cnt_q;
    crd_d       = crd_q;
    rr_ptr_d    = rr_ptr_q;
    req_valid_d = req_valid_q;
    req_qid_d   = req_qid_q;
    ovf_err_d   = ovf_err_q;
    crd_err_d   = crd_err_q;

    for (int q = 0; q < NUM_Q; q++) begin
      if (enq_hit[q] && !gnt_hit[q]) begin
        if (cnt_q[q] == CNT_MAX) begin
          ovf_err_d = 1'b1;
        end else begin
          cnt_d[q] = cnt_q[q] + CNT_W'(1);
        end
      end else if (gnt_hit[q] && !enq_hit[q]) begin
        cnt_d[q] = cnt_q[q] - CNT_W'(1);
      end
    end

    if (grant && !credit_return) begin
      crd_d = crd_q - CRD_W'(1);
    end else if (credit_return && !grant) begin
      if (crd_q == CRD_FULL) begin
        crd_err_d = 1'b1;
      end else begin
        crd_d = crd_q + CRD_W'(1);
      end
    end

    if (slot_free) begin
      req_valid_d = grant;
      if (grant) begin
        req_qid_d = gnt_idx;
        rr_ptr_d  = gnt_idx;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < NUM_Q; q++) begin
        cnt_q[q] <= '0;
      end
      crd_q       <= CRD_FULL;
      rr_ptr_q    <= QID_W'(NUM_Q - 1);
      req_valid_q <= 1'b0;
      req_qid_q   <= '0;
      ovf_err_q   <= 1'b0;
      crd_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      crd_q       <= crd_d;
      rr_ptr_q    <= rr_ptr_d;
      req_valid_q <= req_valid_d;
      req_qid_q   <= req_qid_d;
      ovf_err_q   <= ovf_err_d;
      crd_err_q   <= crd_err_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_qid   = req_qid_q;
  assign ovf_err   = ovf_err_q;
  assign crd_err   = crd_err_q;

endmodule : egr_pfs_sched

// File: tb/tb_egr_pfs_sched.sv
// Directed bench for egr_pfs_sched with hand-computed expectations.
module tb_egr_pfs_sched;
  import egr_pfs_pkg::*;

  logic       clk;
  logic       rst;
  logic       enq_valid;
  qid_t       enq_qid;
  logic [7:0] pause;
  logic       credit_return;
  logic       req_valid;
  logic       req_ready;
  qid_t       req_qid;
  logic       ovf_err;
  logic       crd_err;

  int n_assert = 0;
  int n_fail   = 0;

  egr_pfs_sched dut (
    .clk           (clk),
    .rst           (rst),
    .enq_valid     (enq_valid),
    .enq_qid       (enq_qid),
    .pause         (pause),
    .credit_return (credit_return),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_qid       (req_qid),
    .ovf_err       (ovf_err),
    .crd_err       (crd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs set afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enq_valid = 1'b0;
    credit_return = 1'b0;
    pause = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic enq(input int q);
    enq_valid = 1'b1;
    enq_qid   = qid_t'(q);
    step();
    enq_valid = 1'b0;
  endtask

  int exp_q [4];
  int nq;
  int bad;

  initial begin
    rst = 1'b1;
    enq_valid = 1'b0;
    enq_qid = '0;
    pause = '0;
    credit_return = 1'b0;
    req_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(req_valid), 0);
    chk("rst_qid", 32'(req_qid), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_crderr", 32'(crd_err), 0);
    chk("rst_crd", 32'(dut.crd_q), 4);

    // Single enqueue: request visible two cycles after enqueue, for one cycle
    step(); step(); step();
    enq(3);
    chk("single_t1_valid", 32'(req_valid), 0);
    step();
    chk("single_t2_valid", 32'(req_valid), 1);
    chk("single_t2_qid", 32'(req_qid), 3);
    chk("single_cnt3", 32'(dut.cnt_q[3]), 0);
    step();
    chk("single_t3_valid", 32'(req_valid), 0);
    chk("single_crd", 32'(dut.crd_q), 3);
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    chk("single_crd_back", 32'(dut.crd_q), 4);

    // Round-robin order bounded by credits
    do_reset();
    pause = 8'hFF;
    enq(0); enq(0); enq(2); enq(2); enq(5); enq(5);
    pause = 8'h00;
    exp_q = '{0, 2, 5, 0};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_valid", 32'(req_valid), 1);
      chk("rr_qid", 32'(req_qid), 32'(exp_q[i]));
    end
    step();
    chk("rr_nocrd_valid", 32'(req_valid), 0);
    chk("rr_nocrd_crd", 32'(dut.crd_q), 0);
    credit_return = 1'b1;
    step();
    step();
    credit_return = 1'b0;
    chk("rr_ret_valid0", 32'(req_valid), 1);
    chk("rr_ret_qid0", 32'(req_qid), 2);
    step();
    chk("rr_ret_valid1", 32'(req_valid), 1);
    chk("rr_ret_qid1", 32'(req_qid), 5);
    step();
    chk("rr_ret_idle", 32'(req_valid), 0);

    // Backpressure: held request stays stable; reset restores credits
    do_reset();
    chk("bp_rst_crd", 32'(dut.crd_q), 4);
    chk("bp_rst_valid", 32'(req_valid), 0);
    req_ready = 1'b0;
    pause = 8'hFF;
    enq(1); enq(4);
    pause = 8'h00;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_hold_valid", 32'(req_valid), 1);
      chk("bp_hold_qid", 32'(req_qid), 1);
    end
    req_ready = 1'b1;
    step();
    chk("bp_next_valid", 32'(req_valid), 1);
    chk("bp_next_qid", 32'(req_qid), 4);
    step();
    chk("bp_idle", 32'(req_valid), 0);

    // Pause: q2 blocked while paused, q6 served
    do_reset();
    pause = 8'h04;
    enq(2); enq(2); enq(2); enq(6);
    chk("pause_c4_valid", 32'(req_valid), 0);
    step();
    chk("pause_q6_valid", 32'(req_valid), 1);
    chk("pause_q6_qid", 32'(req_qid), 6);
    step();
    chk("pause_blk0", 32'(req_valid), 0);
    step();
    chk("pause_blk1", 32'(req_valid), 0);
    chk("pause_cnt2", 32'(dut.cnt_q[2]), 3);
    pause = 8'h00;
    step();
    chk("unpause_valid", 32'(req_valid), 1);
    chk("unpause_qid", 32'(req_qid), 2);
    chk("unpause_cnt2", 32'(dut.cnt_q[2]), 2);
    step();
    chk("unpause_qid2", 32'(req_qid), 2);
    step();
    chk("unpause_qid3", 32'(req_qid), 2);
    chk("unpause_cnt2_0", 32'(dut.cnt_q[2]), 0);
    step();
    chk("unpause_idle", 32'(req_valid), 0);
    chk("unpause_crd0", 32'(dut.crd_q), 0);

    // Simultaneous events
    do_reset();
    enq(1);
    enq_valid = 1'b1;
    enq_qid = qid_t'(1);
    step();
    enq_valid = 1'b0;
    chk("sim_enq_cnt1", 32'(dut.cnt_q[1]), 1);
    chk("sim_enq_valid", 32'(req_valid), 1);
    chk("sim_enq_qid", 32'(req_qid), 1);
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    chk("sim_crd_same", 32'(dut.crd_q), 3);
    chk("sim_cnt1_0", 32'(dut.cnt_q[1]), 0);
    chk("sim_valid2", 32'(req_valid), 1);
    credit_return = 1'b1;
    step();
    chk("sim_crd_full", 32'(dut.crd_q), 4);
    chk("sim_crderr_0", 32'(crd_err), 0);
    step();
    credit_return = 1'b0;
    chk("sim_crderr_1", 32'(crd_err), 1);
    chk("sim_crd_stay", 32'(dut.crd_q), 4);

    // Overflow on a paused queue, then drain exactly the saturated count
    do_reset();
    pause = 8'h80;
    for (int i = 0; i < 1023; i++) enq(7);
    chk("ovf_cnt_pre", 32'(dut.cnt_q[7]), 1023);
    chk("ovf_err_pre", 32'(ovf_err), 0);
    enq(7);
    chk("ovf_cnt_sat", 32'(dut.cnt_q[7]), 1023);
    chk("ovf_err_set", 32'(ovf_err), 1);
    pause = 8'h00;
    nq = 0;
    bad = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      credit_return = req_valid;
      if (req_valid) begin
        nq++;
        if (req_qid != qid_t'(7)) bad++;
      end
    end
    credit_return = 1'b0;
    step();
    chk("drain_count", 32'(nq), 1023);
    chk("drain_wrong_qid", 32'(bad), 0);
    chk("drain_cnt7", 32'(dut.cnt_q[7]), 0);
    chk("drain_ovf_sticky", 32'(ovf_err), 1);
    chk("drain_crd", 32'(dut.crd_q), 4);
    chk("drain_crderr", 32'(crd_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_egr_pfs_sched
